alu_writeback: RTL

- Consumer at the far end of the ALU operand path: captures the ALU result (or a memory load result) plus destination register index, and drives the register-file write port.
- Sits after the ALU, mirroring the operand mux that feeds it.
- Updates zero/negative flags.
- Reports completion to the controller with a one-cycle en_out pulse.
- Flags a load that never returns data.

---
 rtl/alu_writeback_if.sv | 31 +++
 rtl/alu_writeback.sv | 97 +++++++++
 2 files changed

// File: rtl/alu_writeback_if.sv
// Bundle between the ALU/memory side and the writeback stage.
// The master drives results and load data; the slave drives the register-file write port and status.
interface alu_writeback_if #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 3
);
    logic              en_in;
    logic              wb_sel;
    logic [AWIDTH-1:0] rd_addr;
    logic [DWIDTH-1:0] alu_y;
    logic [DWIDTH-1:0] mem_rdata;
    logic              mem_valid;
    logic              rf_we;
    logic [AWIDTH-1:0] rf_waddr;
    logic [DWIDTH-1:0] rf_wdata;
    logic              flag_z;
    logic              flag_n;
    logic              busy;
    logic              en_out;
    logic              err;

    modport master (
        output en_in, wb_sel, rd_addr, alu_y, mem_rdata, mem_valid,
        input  rf_we, rf_waddr, rf_wdata, flag_z, flag_n, busy, en_out, err
    );

    modport slave (
        input  en_in, wb_sel, rd_addr, alu_y, mem_rdata, mem_valid,
        output rf_we, rf_waddr, rf_wdata, flag_z, flag_n, busy, en_out, err
    );
endinterface

// File: rtl/alu_writeback.sv
// Writeback stage: takes an ALU result or a pending load, performs one register-file write,
// updates zero/negative flags, and flags loads whose data never arrives.
module alu_writeback #(
    parameter int DWIDTH       = 16,
    parameter int AWIDTH       = 3,
    parameter int TIMEOUT      = 8,
    parameter int R0_HARDWIRED = 1
) (
    input  logic            clk,
    input  logic            rst,
    alu_writeback_if.slave  bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [AWIDTH-1:0] addr_q;
    logic              load_alu, load_mem, timeout;

    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d  = state_q;
        load_alu = 1'b0;
        load_mem = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en_in) begin
                    if (bus.wb_sel) begin
                        state_d = WAIT_MEM;
                    end else begin
                        state_d  = WRITE;
                        load_alu = 1'b1;
                    end
                end
            end
            WAIT_MEM: begin
                // Data arriving on the final wait cycle still beats the timeout.
                if (bus.mem_valid) begin
                    state_d  = WRITE;
                    load_mem = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            bus.flag_z   <= 1'b0;
            bus.flag_n   <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            state_q <= state_d;
            bus.err <= timeout;

            if (state_q == IDLE) begin
                cnt_q <= '0;
                if (bus.en_in) addr_q <= bus.rd_addr;
            end else if (state_q == WAIT_MEM) begin
                cnt_q <= cnt_q + 1'b1;
            end

            // Write-port registers load only on entry to WRITE and hold otherwise.
            if (load_alu) begin
                bus.rf_waddr <= bus.rd_addr;
                bus.rf_wdata <= bus.alu_y;
            end else if (load_mem) begin
                bus.rf_waddr <= addr_q;
                bus.rf_wdata <= bus.mem_rdata;
            end

            if (state_q == WRITE) begin
                bus.flag_z <= (bus.rf_wdata == '0);
                bus.flag_n <= bus.rf_wdata[DWIDTH-1];
            end
        end
    end

    // Flags still follow a suppressed r0 write; only the enable is masked.
    assign bus.busy   = (state_q != IDLE);
    assign bus.en_out = (state_q == WRITE);
    assign bus.rf_we  = (state_q == WRITE) && !((R0_HARDWIRED != 0) && (bus.rf_waddr == '0));
endmodule
